// File: rtl/display_ctrl_pkg.sv
// Shared types and constants for the score/timer display controller.
package display_ctrl_pkg;

  typedef enum logic [1:0] {
    StShow  = 2'd0,
    StConvS = 2'd1,
    StConvT = 2'd2,
    StMsg   = 2'd3
  } state_e;

  localparam logic [6:0]  BcdMax     = 7'd99;
  localparam int unsigned ConvCycles = 7;
  localparam logic [7:0]  BcdRst     = 8'h00;
  localparam logic [15:0] MsgRst     = 16'h0000;

  // One double-dabble iteration on {bcd[7:0], bin[6:0]}: adjust digits >= 5, then shift left.
  function automatic logic [14:0] dd_step(input logic [14:0] v);
    logic [14:0] a;
    a = v;
    if (a[14:11] >= 4'd5) a[14:11] = a[14:11] + 4'd3;
    if (a[10:7] >= 4'd5) a[10:7] = a[10:7] + 4'd3;
    return {a[13:0], 1'b0};
  endfunction

endpackage

// File: rtl/display_ctrl_if.sv
// Game-side inputs and driver-side outputs of the display controller.
interface display_ctrl_if;

  logic        disp_en;
  logic [6:0]  score_bin;
  logic [6:0]  time_bin;
  logic        game_over;
  logic        msg_req;
  logic [15:0] msg_value;
  logic        msg_ack;
  logic [7:0]  left_value;
  logic [7:0]  right_value;
  logic        blank;

  modport master (
    output disp_en, score_bin, time_bin, game_over, msg_req, msg_value,
    input  msg_ack, left_value, right_value, blank
  );

  modport slave (
    input  disp_en, score_bin, time_bin, game_over, msg_req, msg_value,
    output msg_ack, left_value, right_value, blank
  );

endinterface

// File: rtl/display_ctrl_bin2bcd_seq.sv
// Iterative 7-bit binary to 2-digit packed BCD converter, one bit per cycle, saturating at 99.
// bcd/done are valid combinationally during the final step so the caller can load on that edge.
module display_ctrl_bin2bcd_seq
  import display_ctrl_pkg::*;
(
  input  logic       clk_1k,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] bin,
  output logic       done,
  output logic [7:0] bcd
);

  localparam logic [2:0] LastStep = 3'(ConvCycles - 1);

  logic [14:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  bin_sat;
  logic [14:0] step_in;

  always_comb begin
    bin_sat = (bin > BcdMax) ? BcdMax : bin;
    step_in = start ? {8'h00, bin_sat} : acc_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    // start always restarts, so an aborted pass needs no cleanup
    if (start || (cnt_q != 3'd0)) begin
      acc_d = dd_step(step_in);
      if (start) begin
        cnt_d = 3'd1;
      end else if (cnt_q == LastStep) begin
        cnt_d = 3'd0;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  assign done = !start && (cnt_q == LastStep);
  assign bcd  = acc_d[14:7];

  always_ff @(posedge clk_1k or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= 3'd0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_ctrl.sv
// Display content selector: periodic BCD refresh of score/time, message pre-emption, blanking.
// Optional game-over blink is enabled by defining DISP_BLINK_EN.
module display_ctrl
  import display_ctrl_pkg::*;
#(
  parameter int unsigned REFRESH_MS    = 50,
  parameter int unsigned MSG_HOLD_MS   = 1000,
  parameter int unsigned BLINK_HALF_MS = 250
) (
  input logic           clk_1k,
  input logic           rst_n,
  display_ctrl_if.slave bus
);

  localparam int unsigned RefW  = $clog2(REFRESH_MS);
  localparam int unsigned HoldW = $clog2(MSG_HOLD_MS);
  localparam logic [RefW-1:0]  RefMax  = RefW'(REFRESH_MS - 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MSG_HOLD_MS - 1);

  state_e           state_q, state_d;
  logic [RefW-1:0]  refresh_cnt_q, refresh_cnt_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [15:0]      msg_q, msg_d;
  logic             ack_q, ack_d;
  logic [7:0]       left_q, left_d, right_q, right_d, shadow_q, shadow_d;
  logic             conv_first_q, conv_first_d;
  logic             blank_q, blank_d;
  logic             conv_done;
  logic [7:0]       conv_bcd;
  logic [6:0]       conv_bin;

  assign conv_bin = (state_q == StConvT) ? bus.time_bin : bus.score_bin;

  display_ctrl_bin2bcd_seq u_bin2bcd (
    .clk_1k (clk_1k),
    .rst_n  (rst_n),
    .start  (conv_first_q),
    .bin    (conv_bin),
    .done   (conv_done),
    .bcd    (conv_bcd)
  );

  always_comb begin
    state_d       = state_q;
    refresh_cnt_d = refresh_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    msg_d         = msg_q;
    ack_d         = 1'b0;
    left_d        = left_q;
    right_d       = right_q;
    shadow_d      = shadow_q;
    conv_first_d  = 1'b0;
    unique case (state_q)
      StShow: begin
        if (refresh_cnt_q != RefMax) refresh_cnt_d = refresh_cnt_q + 1'b1;
        if (bus.msg_req && bus.disp_en) begin
          state_d    = StMsg;
          ack_d      = 1'b1;
          msg_d      = bus.msg_value;
          hold_cnt_d = '0;
        end else if ((refresh_cnt_q == RefMax) && bus.disp_en) begin
          state_d       = StConvS;
          refresh_cnt_d = '0;
          conv_first_d  = 1'b1;
        end
      end
      StConvS: begin
        if (!bus.disp_en) begin
          state_d = StShow;
        end else if (conv_done) begin
          shadow_d     = conv_bcd;
          state_d      = StConvT;
          conv_first_d = 1'b1;
        end
      end
      StConvT: begin
        if (!bus.disp_en) begin
          state_d = StShow;
        end else if (conv_done) begin
          // Both bytes commit on this one edge so the driver never sees a torn pair.
          left_d  = shadow_q;
          right_d = conv_bcd;
          state_d = StShow;
        end
      end
      StMsg: begin
        if (!bus.disp_en) begin
          state_d = StShow;
        end else if (hold_cnt_q == HoldMax) begin
          state_d       = StConvS;
          refresh_cnt_d = '0;
          conv_first_d  = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = StShow;
    endcase
  end

`ifdef DISP_BLINK_EN
  localparam int unsigned BlinkW = $clog2(BLINK_HALF_MS);
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_HALF_MS - 1);

  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_q, blink_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (!bus.game_over) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (bus.disp_en && (state_q != StMsg)) begin
      if (blink_cnt_q == BlinkMax) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_1k or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign blank_d = ~bus.disp_en | (blink_d & (state_d != StMsg));
`else
  logic unused_blink;
  assign unused_blink = bus.game_over ^ (BLINK_HALF_MS == 0);
  assign blank_d      = ~bus.disp_en;
`endif

  always_ff @(posedge clk_1k or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StShow;
      refresh_cnt_q <= '0;
      hold_cnt_q    <= '0;
      msg_q         <= MsgRst;
      ack_q         <= 1'b0;
      left_q        <= BcdRst;
      right_q       <= BcdRst;
      shadow_q      <= BcdRst;
      conv_first_q  <= 1'b0;
      blank_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      refresh_cnt_q <= refresh_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      msg_q         <= msg_d;
      ack_q         <= ack_d;
      left_q        <= left_d;
      right_q       <= right_d;
      shadow_q      <= shadow_d;
      conv_first_q  <= conv_first_d;
      blank_q       <= blank_d;
    end
  end

  assign bus.msg_ack     = ack_q;
  assign bus.left_value  = (state_q == StMsg) ? msg_q[15:8] : left_q;
  assign bus.right_value = (state_q == StMsg) ? msg_q[7:0]  : right_q;
  assign bus.blank       = blank_q;

endmodule

// File: tb/tb_display_ctrl.sv
// Directed bench for display_ctrl; expected values are hand-traced edge numbers after reset release.
module tb_display_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   lat, held, ack_bad, hi, target, base;

  display_ctrl_if dif ();

  display_ctrl u_dut (
    .clk_1k (clk),
    .rst_n  (rst_n),
    .bus    (dif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    dif.disp_en   = 1'b1;
    dif.score_bin = 7'd42;
    dif.time_bin  = 7'd7;
    dif.game_over = 1'b0;
    dif.msg_req   = 1'b0;
    dif.msg_value = 16'h0000;
    #12;
    check("rst_left", dif.left_value, 8'h00);
    check("rst_right", dif.right_value, 8'h00);
    check("rst_blank", dif.blank, 1'b1);
    check("rst_ack", dif.msg_ack, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // First pass: refresh expires at edge 50, outputs load at edge 64.
    go_to(1);
    check("blank_after_en", dif.blank, 1'b0);
    go_to(63);
    check("pre_load_left", dif.left_value, 8'h00);
    check("pre_load_right", dif.right_value, 8'h00);
    go_to(64);
    check("p1_left", dif.left_value, 8'h42);
    check("p1_right", dif.right_value, 8'h07);
    check("p1_blank", dif.blank, 1'b0);

    // Saturation and zero.
    dif.score_bin = 7'd120;
    dif.time_bin  = 7'd99;
    go_to(128);
    check("sat_left", dif.left_value, 8'h99);
    check("sat_right", dif.right_value, 8'h99);
    dif.score_bin = 7'd0;
    go_to(192);
    check("zero_left", dif.left_value, 8'h00);
    check("p3_right", dif.right_value, 8'h99);

    // Score sampled at edge 243; the change at 245 must not leak into this pass.
    dif.score_bin = 7'd55;
    dif.time_bin  = 7'd7;
    go_to(245);
    dif.score_bin = 7'd11;
    go_to(255);
    check("no_tear_left", dif.left_value, 8'h00);
    check("no_tear_right", dif.right_value, 8'h99);
    go_to(256);
    check("p4_left", dif.left_value, 8'h55);
    check("p4_right", dif.right_value, 8'h07);

    // Message requested mid CONV_S (306..312); accepted once back in SHOW.
    go_to(308);
    dif.msg_req   = 1'b1;
    dif.msg_value = 16'h1234;
    lat = 0;
    while (!dif.msg_ack && lat < 20) begin
      tick();
      lat++;
    end
    check("ack1_seen", dif.msg_ack, 1'b1);
    check("ack1_latency_le15", (lat <= 15), 1'b1);
    check("msg1_left", dif.left_value, 8'h12);
    check("msg1_right", dif.right_value, 8'h34);
    tick();
    check("ack1_pulse", dif.msg_ack, 1'b0);
    // Second request held through the whole hold: must be ignored until SHOW.
    dif.msg_value = 16'h5678;
    dif.score_bin = 7'd33;
    held    = 1;
    ack_bad = 0;
    while (dif.left_value == 8'h12 && dif.right_value == 8'h34 && held < 1100) begin
      if (dif.msg_ack) ack_bad++;
      held++;
      tick();
    end
    check("msg1_hold", held, 1000);
    check("no_ack_in_msg", ack_bad, 0);
    check("restore_left", dif.left_value, 8'h11);
    check("restore_right", dif.right_value, 8'h07);
    go_to(1334);
    check("pre_refresh_left", dif.left_value, 8'h11);
    go_to(1335);
    check("post_msg_left", dif.left_value, 8'h33);
    check("post_msg_right", dif.right_value, 8'h07);
    lat = 0;
    while (!dif.msg_ack && lat < 30) begin
      tick();
      lat++;
    end
    check("ack2_latency", lat, 1);
    check("msg2_left", dif.left_value, 8'h56);
    check("msg2_right", dif.right_value, 8'h78);
    dif.msg_req = 1'b0;
    tick();
    check("ack2_pulse", dif.msg_ack, 1'b0);
    held = 1;
    while (dif.left_value == 8'h56 && dif.right_value == 8'h78 && held < 1100) begin
      held++;
      tick();
    end
    check("msg2_hold", held, 1000);
    go_to(2350);
    check("p_after_msg2_left", dif.left_value, 8'h33);

    // disp_en drop mid CONV_T (2407..2413).
    dif.score_bin = 7'd77;
    dif.time_bin  = 7'd88;
    go_to(2409);
    dif.disp_en = 1'b0;
    go_to(2410);
    check("dis_blank", dif.blank, 1'b1);
    check("dis_left", dif.left_value, 8'h33);
    check("dis_right", dif.right_value, 8'h07);
    go_to(2414);
    check("abort_no_load", dif.left_value, 8'h33);
    go_to(2420);
    check("dis_blank_hold", dif.blank, 1'b1);
    dif.disp_en = 1'b1;
    go_to(2421);
    check("reen_blank", dif.blank, 1'b0);
    go_to(2473);
    check("fresh_pre_left", dif.left_value, 8'h33);
    go_to(2474);
    check("fresh_left", dif.left_value, 8'h77);
    check("fresh_right", dif.right_value, 8'h88);

    // Game-over blink.
    dif.game_over = 1'b1;
`ifdef DISP_BLINK_EN
    lat = 0;
    while (!dif.blank && lat < 300) begin
      tick();
      lat++;
    end
    check("blink_first_rise", lat, 250);
    repeat (100) tick();
    check("blink_high", dif.blank, 1'b1);
    dif.game_over = 1'b0;
    tick();
    check("blink_clear", dif.blank, 1'b0);
    dif.game_over = 1'b1;
    lat = 0;
    while (!dif.blank && lat < 300) begin
      tick();
      lat++;
    end
    check("blink_restart", lat, 250);
`else
    hi = 0;
    repeat (600) begin
      tick();
      if (dif.blank) hi++;
    end
    check("no_blink", hi, 0);
`endif
    dif.game_over = 1'b0;

    // Reset in the middle of CONV_T, then a clean first pass.
    target = 2534;
    while (target <= cyc) target += 64;
    go_to(target);
    rst_n = 1'b0;
    #1;
    check("midrst_left", dif.left_value, 8'h00);
    check("midrst_right", dif.right_value, 8'h00);
    check("midrst_blank", dif.blank, 1'b1);
    check("midrst_ack", dif.msg_ack, 1'b0);
    #1;
    rst_n = 1'b1;
    base  = cyc;
    go_to(base + 63);
    check("rst2_pre_left", dif.left_value, 8'h00);
    go_to(base + 64);
    check("rst2_left", dif.left_value, 8'h77);
    check("rst2_right", dif.right_value, 8'h88);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
